// File: rtl/btn_event_pkg.sv
// Shared types and default timing constants for the push-button event generator.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam int DEF_LONG_TICKS   = 500;
  localparam int DEF_REPEAT_TICKS = 100;

endpackage

// File: rtl/hold_timer.sv
// Hold-duration counter: synchronous clear, tick-enabled increment, and a flag
// that is high while the count equals the supplied terminal value.
module hold_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] terminal,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == terminal);

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat strobes.
// Auto-repeat in the LONG state is built only when BTN_AUTO_REPEAT_EN is defined.
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_TICKS - 1);

  state_t           state, state_n;
  logic             btn_prev;
  logic             rise, fall;
  logic             press_n, release_n, long_n, repeat_n;
  logic             tmr_clear, tmr_inc, tmr_tc;
  logic [CNT_W-1:0] tmr_term;

  assign rise     = btn_level & ~btn_prev;
  assign fall     = ~btn_level & btn_prev;
  assign tmr_term = (state == PRESS) ? LONG_TERM : REPEAT_TERM;

  hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .inc      (tmr_inc),
    .terminal (tmr_term),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_n   = state;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    tmr_clear = 1'b0;
    tmr_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n   = PRESS;
          press_n   = 1'b1;
          tmr_clear = 1'b1;
        end
      end
      PRESS: begin
        // A release always beats a threshold tick in the same cycle.
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          tmr_clear = 1'b1;
        end else if (tick_en) begin
          if (tmr_tc) begin
            state_n   = LONG;
            long_n    = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          tmr_clear = 1'b1;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (tick_en) begin
          if (tmr_tc) begin
            repeat_n  = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_n   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // btn_prev resets high so a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      btn_prev      <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_n;
      btn_prev      <= btn_level;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
      held          <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen (LONG_TICKS=4, REPEAT_TICKS=2).
module tb_button_event_gen;

  localparam int LT = 4;
  localparam int RT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_en = 1'b0;
  logic btn_level = 1'b0;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;

  // Reference model: "pressed" flag plus a count of ticks seen while held.
  bit m_pressed = 1'b0;
  bit m_prev = 1'b1;
  int m_ticks = 0;
  logic [4:0] exp_q[$];

  logic [4:0] got, want;
  int n_press, n_rel, n_long, n_rep, n_held;

  button_event_gen #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_en       (tick_en),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
  endfunction

  function automatic logic tick_now();
    return (cyc_n % 3 == 2);
  endfunction

  // Drives one clock cycle, advances the model and tallies observed pulses.
  task automatic cyc(input logic lvl, input logic tk, input logic rst);
    logic [4:0] e;
    bit rise, fall;
    @(negedge clk);
    btn_level = lvl;
    tick_en = tk;
    reset = rst;
    @(posedge clk);
    #1;
    e = '0;
    if (rst) begin
      m_pressed = 1'b0;
      m_prev = 1'b1;
      m_ticks = 0;
    end else begin
      rise = lvl && !m_prev;
      fall = !lvl && m_prev;
      if (!m_pressed) begin
        if (rise) begin
          m_pressed = 1'b1;
          m_ticks = 0;
          e[4] = 1'b1;
        end
      end else if (fall) begin
        m_pressed = 1'b0;
        e[3] = 1'b1;
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == LT) e[2] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        if (m_ticks > LT && (m_ticks - LT) % RT == 0) e[1] = 1'b1;
`endif
      end
      m_prev = lvl;
      e[0] = m_pressed;
    end
    exp_q.push_back(e);
    cyc_n++;
    n_press += int'(press_pulse);
    n_rel += int'(release_pulse);
    n_long += int'(long_pulse);
    n_rep += int'(repeat_pulse);
    n_held += int'(held);
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_held = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want || got !== 5'b0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b want 00000", i, got);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
  endtask

  task automatic test_short_press();
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      cyc((i < 6), tick_now(), 1'b0);
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL short_press cycle %0d: got %b want %b", i, got, want);
      end
    end
    checks++;
    if (n_press !== 1 || n_rel !== 1 || n_long !== 0 || n_held !== 6) begin
      errors++;
      $display("FAIL short_press counts: press=%0d rel=%0d long=%0d held=%0d want 1 1 0 6",
               n_press, n_rel, n_long, n_held);
    end
  endtask

  task automatic test_long_press();
    int ticks_seen, tick4_at, long_at;
    logic tk;
    clear_counts();
    ticks_seen = 0; tick4_at = -1; long_at = -2;
    for (int i = 0; i < 46; i++) begin
      tk = tick_now();
      if (i > 0 && i < 40 && tk) begin
        ticks_seen++;
        if (ticks_seen == LT) tick4_at = i;
      end
      cyc((i < 40), tk, 1'b0);
      if (long_pulse) long_at = i;
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL long_press cycle %0d: got %b want %b", i, got, want);
      end
    end
    checks++;
    if (n_long !== 1 || long_at !== tick4_at) begin
      errors++;
      $display("FAIL long_press timing: long count %0d at %0d, want 1 at %0d", n_long, long_at, tick4_at);
    end
    checks++;
`ifdef BTN_AUTO_REPEAT_EN
    if (n_rep !== (ticks_seen - LT) / RT) begin
      errors++;
      $display("FAIL long_press repeats: got %0d want %0d", n_rep, (ticks_seen - LT) / RT);
    end
`else
    if (n_rep !== 0) begin
      errors++;
      $display("FAIL long_press repeats: got %0d want 0", n_rep);
    end
`endif
  endtask

  task automatic test_release_on_threshold();
    logic lvl, tk;
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      lvl = (i <= 11);
      tk = (i % 3 == 0) && (i > 0);
      cyc(lvl, tk, 1'b0);
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL release_on_threshold cycle %0d: got %b want %b", i, got, want);
      end
    end
    checks++;
    if (n_rel !== 1 || n_long !== 0 || n_rep !== 0) begin
      errors++;
      $display("FAIL release_on_threshold counts: rel=%0d long=%0d rep=%0d want 1 0 0", n_rel, n_long, n_rep);
    end
  endtask

  task automatic test_held_through_reset();
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      cyc((i < 9) || (i >= 11), tick_now(), (i < 3));
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL held_through_reset cycle %0d: got %b want %b", i, got, want);
      end
      if (i == 8) begin
        checks++;
        if (n_press !== 0) begin
          errors++;
          $display("FAIL held_through_reset no_press: got %0d press pulses want 0", n_press);
        end
      end
      if (i == 11) begin
        checks++;
        if (press_pulse !== 1'b1) begin
          errors++;
          $display("FAIL held_through_reset repress: press_pulse=%b want 1", press_pulse);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_long();
    logic lvl, tk, rst;
    for (int i = 0; i < 27; i++) begin
      lvl = (i >= 1) && (i < 24);
      tk = (i % 3 == 0) && (i > 1);
      rst = (i == 17);
      if (i == 17) clear_counts();
      cyc(lvl, tk, rst);
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_long cycle %0d: got %b want %b", i, got, want);
      end
      if (i == 16) begin
        checks++;
        if (held !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_long in_long: held=%b want 1", held);
        end
      end
      if (i == 17) begin
        checks++;
        if (held !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_long after_reset: held=%b want 0", held);
        end
      end
    end
    checks++;
    if (n_rel !== 0 || n_rep !== 0 || n_press !== 0) begin
      errors++;
      $display("FAIL reset_mid_long counts: rel=%0d rep=%0d press=%0d want 0 0 0", n_rel, n_rep, n_press);
    end
  endtask

  task automatic test_random();
    logic lvl, tk, rst;
    lvl = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) lvl = ~lvl;
      tk = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cyc(lvl, tk, rst);
      want = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, got, want);
      end
      checks++;
      if ($countones(got[4:1]) > 1) begin
        errors++;
        $display("FAIL random onehot cycle %0d: pulses %b want at most one high", i, got[4:1]);
      end
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_short_press();
    test_long_press();
    test_release_on_threshold();
    test_held_through_reset();
    test_reset_mid_long();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumer end of the push-button conditioning path.
- Takes an already-debounced button level and turns it into single-cycle event strobes: press, release, long-press and auto-repeat.
- Feeds the alarm-clock control FSM, e.g. hold SET to fast-advance minutes.
- One instance per button; time base comes from an external tick_en strobe.

Parameters:
- LONG_TICKS, 500, tick_en periods the button must be held before long_pulse (must be >= 2).
- REPEAT_TICKS, 100, tick_en periods between successive repeat_pulse strobes after long press (must be >= 1).
- CNT_W, 16, hold-counter width; must satisfy 2**CNT_W > max(LONG_TICKS, REPEAT_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  one-cycle time-base strobe (e.g. 1 kHz).
- btn_level  in  1  debounced button level, 1 = pressed.
- press_pulse  out  1  one-cycle strobe on press.
- release_pulse  out  1  one-cycle strobe on release.
- long_pulse  out  1  one-cycle strobe when hold reaches LONG_TICKS.
- repeat_pulse  out  1  one-cycle strobe every REPEAT_TICKS after long press.
- held  out  1  level, 1 while FSM is not IDLE.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on reset.
- All outputs are registered.

Reset:
- state=IDLE, cnt=0, all pulses 0, held=0.
- btn_prev is loaded with 1. A button held through reset therefore produces no press_pulse until it is released and pressed again.

Edge detect:
- btn_prev <= btn_level every cycle.
- rise = btn_level & ~btn_prev; fall = ~btn_level & btn_prev.

States:
- IDLE: on rise, go to PRESS, cnt<=0, press_pulse=1 the next cycle (1-cycle latency from btn_level rising).
- PRESS:
  - fall has priority: go to IDLE, release_pulse=1 the next cycle, cnt<=0.
  - Else on tick_en: if cnt==LONG_TICKS-1, go to LONG, cnt<=0, long_pulse=1 the next cycle. Otherwise cnt<=cnt+1.
- LONG:
  - fall: go to IDLE, release_pulse, cnt<=0.
  - Else on tick_en: if cnt==REPEAT_TICKS-1, cnt<=0 and repeat_pulse=1 the next cycle. Otherwise cnt<=cnt+1.

Rules and boundaries:
- held = (state != IDLE), registered, asserted in the same cycle as press_pulse.
- Release on the same cycle as a threshold tick: release wins; no long_pulse or repeat_pulse is issued.
- At most one pulse output is high in any cycle.
- cnt never exceeds the active threshold minus 1, so there is no wrap.
- tick_en is ignored in IDLE.
- Reset mid-hold: all pulses drop the cycle after reset. Any pending threshold is discarded; no release_pulse is emitted.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: LONG state emits repeat_pulse as described above.
- Undefined: repeat_pulse is tied to 0, the cnt increment in LONG is removed, and LONG simply waits for release. long_pulse is unaffected.

Decomposition:
- Package btn_event_pkg: state typedef (IDLE, PRESS, LONG, 2-bit) and default constants for LONG_TICKS and REPEAT_TICKS.
- One natural sub-module, hold_timer: loadable CNT_W counter with clear, tick-enable, terminal-value input and a terminal-count flag. The FSM owns state and pulse registers.

Test Plan (LONG_TICKS=4, REPEAT_TICKS=2, tick_en high every 3rd cycle):
- Short press: btn_level high for 6 cycles then low -> exactly one press_pulse and one release_pulse; long_pulse never asserted; held high for 6 cycles.
- Long press: hold for 40 cycles -> long_pulse exactly once, one cycle after the 4th tick_en following the press. With BTN_AUTO_REPEAT_EN, repeat_pulse follows every 2nd subsequent tick (every 6 cycles) until release.
- Release on the threshold tick: drop btn_level in the same cycle as the 4th tick_en -> release_pulse only; no long_pulse.
- Held through reset: btn_level=1 during and after a 3-cycle reset pulse -> no press_pulse. Release then re-press -> press_pulse 1 cycle after the rise.
- Reset mid-LONG: assert reset for 1 cycle while in LONG -> state IDLE and held=0 the next cycle; no release_pulse or repeat_pulse.
- Macro off: same stimulus as the long-press scenario -> long_pulse once, repeat_pulse stays 0 for the full 40 cycles.
